dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arb_pkg.sv | 22 ++
 rtl/dm_arb_wait_ctr.sv | 36 +++
 rtl/dm_arbiter.sv | 131 +++++++++++++
 tb/tb_dm_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// ============================================================================
// Module   : dm_arb_pkg
// Brief    : Shared types and constants for the data-memory arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dm_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        LOCK1 = 1'b1
    } arb_state_t;

    localparam int PORT_CPU      = 0;
    localparam int PORT_DMA      = 1;
    localparam int DEF_MAX_WAIT  = 8;
    localparam int DEF_BURST_MAX = 16;

endpackage

`default_nettype wire

// File: rtl/dm_arb_wait_ctr.sv
// ============================================================================
// Module   : dm_arb_wait_ctr
// Brief    : Saturating count of consecutive denied DMA cycles; flags starve.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dm_arb_wait_ctr #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic i_gnt,
    output logic o_starve
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_req || i_gnt) begin
            r_cnt <= '0;
        end else if (r_cnt != CW'(MAX_WAIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_starve = (r_cnt == CW'(MAX_WAIT));

endmodule

`default_nettype wire

// File: rtl/dm_arbiter.sv
// ============================================================================
// Module   : dm_arbiter
// Brief    : Two-port (CPU/DMA) arbiter in front of a single-port data memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int MAX_WAIT  = DEF_MAX_WAIT,
    parameter int BURST_MAX = DEF_BURST_MAX,
    parameter int AW        = 13
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic [3:0]    m0_byteen,
    input  logic [31:0]   m0_addr,
    input  logic [31:0]   m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    input  logic          m1_req,
    input  logic [3:0]    m1_byteen,
    input  logic [31:0]   m1_addr,
    input  logic [31:0]   m1_wdata,
    input  logic          m1_lock,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    output logic [3:0]    dm_wea,
    output logic [AW-1:0] dm_addra,
    output logic [31:0]   dm_dina,
    input  logic [31:0]   dm_douta
);

    localparam int BW = $clog2(BURST_MAX + 1);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic [BW-1:0] r_burst;
    logic [BW-1:0] w_burst_inc;
    logic [BW-1:0] w_burst_cur;
    logic          r_release;
    logic          r_m0_rvalid;
    logic          r_m1_rvalid;
    logic          w_starve;
    logic          w_burst_done;
    logic [1:0]    w_gnt;
    logic          w_unused;

    dm_arb_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .clk      (clk),
        .rst      (reset),
        .i_req    (m1_req),
        .i_gnt    (w_gnt[PORT_DMA]),
        .o_starve (w_starve)
    );

    // Beat count this DMA grant would reach; an IDLE grant is beat 1.
    assign w_burst_inc  = r_burst + 1'b1;
    assign w_burst_cur  = (r_state == LOCK1) ? w_burst_inc : BW'(1);
    assign w_burst_done = w_gnt[PORT_DMA] && m1_lock && (w_burst_cur == BW'(BURST_MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_gnt[PORT_DMA] && m1_lock && !w_burst_done) w_state_nxt = LOCK1;
            LOCK1:   if (!m1_req || !m1_lock || w_burst_done)         w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // The release flag lets the CPU in right after a full-length burst.
    always_comb begin
        w_gnt = 2'b00;
        if (!reset) begin
            if (r_state == LOCK1) begin
                if (m1_req)      w_gnt[PORT_DMA] = 1'b1;
                else if (m0_req) w_gnt[PORT_CPU] = 1'b1;
            end else if (m0_req && (!w_starve || r_release)) begin
                w_gnt[PORT_CPU] = 1'b1;
            end else if (m1_req) begin
                w_gnt[PORT_DMA] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_burst     <= '0;
            r_release   <= 1'b0;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
        end else begin
            r_burst     <= (w_state_nxt == LOCK1) ? w_burst_cur : '0;
            r_release   <= w_burst_done && m0_req;
            r_m0_rvalid <= w_gnt[PORT_CPU] && (m0_byteen == 4'b0000);
            r_m1_rvalid <= w_gnt[PORT_DMA] && (m1_byteen == 4'b0000);
        end
    end

    assign m0_gnt    = w_gnt[PORT_CPU];
    assign m1_gnt    = w_gnt[PORT_DMA];
    assign m0_rvalid = r_m0_rvalid;
    assign m1_rvalid = r_m1_rvalid;
    assign m0_rdata  = dm_douta;
    assign m1_rdata  = dm_douta;

    assign dm_wea   = w_gnt[PORT_DMA] ? m1_byteen :
                      (w_gnt[PORT_CPU] ? m0_byteen : 4'b0000);
    assign dm_addra = w_gnt[PORT_DMA] ? m1_addr[AW+1:2] : m0_addr[AW+1:2];
    assign dm_dina  = w_gnt[PORT_DMA] ? m1_wdata : m0_wdata;

    // Address bits outside the word-address window are intentionally dropped.
    assign w_unused = ^{m0_addr[31:AW+2], m0_addr[1:0], m1_addr[31:AW+2], m1_addr[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_dm_arbiter.sv
// ============================================================================
// Module   : tb_dm_arbiter
// Brief    : Directed self-checking bench for dm_arbiter with a small DM model.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m0_req, m1_req, m1_lock;
    logic [3:0]  m0_byteen, m1_byteen;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [3:0]  dm_wea;
    logic [12:0] dm_addra;
    logic [31:0] dm_dina;
    logic [31:0] dm_douta;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];

    dm_arbiter u_dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_byteen (m0_byteen),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_byteen (m1_byteen),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_lock   (m1_lock),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .dm_wea    (dm_wea),
        .dm_addra  (dm_addra),
        .dm_dina   (dm_dina),
        .dm_douta  (dm_douta)
    );

    always #5 clk = ~clk;

    // Single-port memory, one-cycle read latency, byte-enabled writes.
    always @(posedge clk) begin
        if (dm_wea[0]) mem[dm_addra[7:0]][7:0]   <= dm_dina[7:0];
        if (dm_wea[1]) mem[dm_addra[7:0]][15:8]  <= dm_dina[15:8];
        if (dm_wea[2]) mem[dm_addra[7:0]][23:16] <= dm_dina[23:16];
        if (dm_wea[3]) mem[dm_addra[7:0]][31:24] <= dm_dina[31:24];
        dm_douta <= mem[dm_addra[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m0_byteen = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_byteen = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
        m1_lock = 1'b0;
    endtask

    initial begin
        idle_inputs();
        // Reset: grants gated off, DM address follows m0
        #1 reset = 1'b1;
        m0_req = 1'b1; m0_byteen = 4'hF; m0_addr = 32'h0000_0024;
        #1;
        chk("rst_m0_gnt", {31'b0, m0_gnt}, 32'd0);
        chk("rst_m1_gnt", {31'b0, m1_gnt}, 32'd0);
        chk("rst_wea", {28'b0, dm_wea}, 32'h0);
        chk("rst_addra", {19'b0, dm_addra}, 32'd9);
        chk("rst_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
        tick(); tick();
        reset = 1'b0;
        idle_inputs();
        tick();

        // Lone DMA partial write
        m1_req = 1'b1; m1_byteen = 4'b0011; m1_addr = 32'h0000_0008; m1_wdata = 32'h1234_5678;
        #1;
        chk("w1_gnt", {30'b0, m1_gnt, m0_gnt}, 32'b10);
        chk("w1_wea", {28'b0, dm_wea}, 32'h3);
        chk("w1_addra", {19'b0, dm_addra}, 32'd2);
        chk("w1_dina", dm_dina, 32'h1234_5678);
        tick(); idle_inputs();
        chk("w1_no_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);

        // CPU write then read of word 4
        m0_req = 1'b1; m0_byteen = 4'hF; m0_addr = 32'h0000_0010; m0_wdata = 32'hDEAD_BEEF;
        #1;
        chk("w0_gnt", {30'b0, m1_gnt, m0_gnt}, 32'b01);
        chk("w0_addra", {19'b0, dm_addra}, 32'd4);
        tick(); idle_inputs();
        chk("w0_no_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
        m0_req = 1'b1; m0_byteen = 4'h0; m0_addr = 32'h0000_0010;
        #1;
        chk("r0_gnt", {31'b0, m0_gnt}, 32'd1);
        chk("r0_addra", {19'b0, dm_addra}, 32'd4);
        chk("r0_wea", {28'b0, dm_wea}, 32'h0);
        tick(); idle_inputs();
        chk("r0_rvalid", {31'b0, m0_rvalid}, 32'd1);
        chk("r0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("r0_m1_rvalid", {31'b0, m1_rvalid}, 32'd0);
        tick();
        chk("r0_rvalid_drop", {31'b0, m0_rvalid}, 32'd0);

        // Out-of-range address wraps and is still a write
        m0_req = 1'b1; m0_byteen = 4'b0101; m0_addr = 32'h0000_800C;
        #1;
        chk("wrap_addra", {19'b0, dm_addra}, 32'd3);
        chk("wrap_wea", {28'b0, dm_wea}, 32'h5);
        tick(); idle_inputs();
        chk("wrap_no_rvalid", {31'b0, m0_rvalid}, 32'd0);

        // DMA read of word 4
        m1_req = 1'b1; m1_addr = 32'h0000_0010;
        tick(); idle_inputs();
        chk("r1_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'b10);
        chk("r1_rdata", m1_rdata, 32'hDEAD_BEEF);
        tick();

        // Starvation: m1 forced in after MAX_WAIT denials
        m0_req = 1'b1; m0_byteen = 4'hF; m0_addr = 32'h0000_0020;
        m1_req = 1'b1; m1_byteen = 4'hF; m1_addr = 32'h0000_0040;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("starve_c%0d", i), {30'b0, m1_gnt, m0_gnt},
                (i == 8) ? 32'b10 : 32'b01);
            tick();
        end
        idle_inputs();
        tick();

        // Locked burst capped at 16, one-cycle CPU release, then starvation again
        m0_req = 1'b1; m0_byteen = 4'hF; m0_addr = 32'h0000_0020;
        m1_req = 1'b1; m1_byteen = 4'hF; m1_addr = 32'h0000_0040; m1_lock = 1'b1;
        for (int j = 0; j < 33; j++) begin
            #1;
            chk($sformatf("burst_c%0d", j), {30'b0, m1_gnt, m0_gnt},
                ((j >= 8 && j <= 23) || j == 32) ? 32'b10 : 32'b01);
            tick();
        end
        idle_inputs();
        tick();

        // Reset mid-burst with reads in flight
        m1_req = 1'b1; m1_lock = 1'b1; m1_byteen = 4'h0; m1_addr = 32'h0000_0010;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("rb_gnt%0d", k), {30'b0, m1_gnt, m0_gnt}, 32'b10);
            if (k == 1) chk("rb_rdata", m1_rdata, 32'hDEAD_BEEF);
            if (k < 4) tick();
        end
        #2 reset = 1'b1;
        #1;
        chk("rb_rst_gnt", {30'b0, m1_gnt, m0_gnt}, 32'b00);
        chk("rb_rst_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
        tick();
        chk("rb_rst_rvalid2", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
        m0_req = 1'b1; m0_byteen = 4'hF; m0_addr = 32'h0000_0020;
        reset = 1'b0;
        #1;
        chk("rb_post_gnt", {30'b0, m1_gnt, m0_gnt}, 32'b01);
        tick();
        chk("rb_post_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
